spi_regbank_slave: RTL and testbench



---
 rtl/spi_regbank_pkg.sv | 36 +++
 rtl/spi_regbank_slave_if.sv | 38 +++
 rtl/spi_shift_reg.sv | 30 +++
 rtl/spi_regbank_slave.sv | 225 ++++++++++++++++++++++
 tb/tb_spi_regbank_slave.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/spi_regbank_pkg.sv
// spi_regbank_pkg
// Shared types and constants for the SPI register-bank slave:
//   - state_e     : frame decoder states (HDR, DATA, SKIP)
//   - OP_WR/OP_RD : value of the first frame bit for write / read
//   - header field offsets and the header length as functions of DEV_W
//     and ADDR_W
// Header bit order on the wire (bit 0 is sampled first):
//   [0] WR, [1 +: DEV_W] device address, [1+DEV_W] reserved,
//   [2+DEV_W +: ADDR_W] start register address.
package spi_regbank_pkg;

   typedef enum logic [1:0] {
      HDR  = 2'd0,
      DATA = 2'd1,
      SKIP = 2'd2
   } state_e;

   localparam logic OP_WR = 1'b1;
   localparam logic OP_RD = 1'b0;

   localparam int HDR_WR_OFS  = 0;
   localparam int HDR_DEV_OFS = 1;

   function automatic int hdr_rsv_ofs(input int dev_w);
      return 1 + dev_w;
   endfunction

   function automatic int hdr_addr_ofs(input int dev_w);
      return 2 + dev_w;
   endfunction

   function automatic int hdr_len(input int dev_w, input int addr_w);
      return dev_w + addr_w + 2;
   endfunction

endpackage

// File: rtl/spi_regbank_slave_if.sv
// spi_regbank_slave_if
// Bundles the SPI bus pins and the host-side outputs of the register-bank
// slave.
//   cs, mosi            : SPI bus from master
//   miso, miso_oe       : SPI data back to master and its tristate enable
//   wr_strobe/addr/data : one-cycle notification of a committed word
//   regs_flat           : all registers, reg i at [i*DATA_W +: DATA_W]
//   dbg_state           : current frame decoder state
// Handshake: there is no valid/ready pair here; wr_strobe is a one-cycle
// qualifier for wr_addr/wr_data and the consumer must always accept it.
// miso is only meaningful while miso_oe is high.
interface spi_regbank_slave_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) ();
   import spi_regbank_pkg::*;

   logic                           cs;
   logic                           mosi;
   logic                           miso;
   logic                           miso_oe;
   logic                           wr_strobe;
   logic [ADDR_W-1:0]              wr_addr;
   logic [DATA_W-1:0]              wr_data;
   logic [DATA_W*(2**ADDR_W)-1:0]  regs_flat;
   state_e                         dbg_state;

   modport slave (
      input  cs, mosi,
      output miso, miso_oe, wr_strobe, wr_addr, wr_data, regs_flat, dbg_state
   );

   modport master (
      output cs, mosi,
      input  miso, miso_oe, wr_strobe, wr_addr, wr_data, regs_flat, dbg_state
   );

endinterface

// File: rtl/spi_shift_reg.sv
// spi_shift_reg
// W-bit serial-in shift register with parallel load, shifting towards the
// MSB so that q[W-1] is the serial output.
//   sclk, rst : clock, synchronous active-high reset
//   load      : parallel load of load_val (wins over shift_en)
//   shift_en  : shift one place left, sin enters at bit 0
//   q         : current contents
module spi_shift_reg #(
   parameter int W = 8
) (
   input  logic         sclk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         shift_en,
   input  logic         sin,
   output logic [W-1:0] q
);

   always_ff @(posedge sclk) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (shift_en) begin
         q <= {q[W-2:0], sin};
      end
   end

endmodule

// File: rtl/spi_regbank_slave.sv
// spi_regbank_slave
// SPI slave with a 2**ADDR_W x DATA_W register bank on a multi-drop bus.
// A frame (cs high) carries a header (WR, device address, reserved bit,
// start address) followed by any number of DATA_W-bit words, MSB first.
// Frames for another device address are ignored. Bursts auto-increment
// the register address modulo the bank size.
// Ports:
//   sclk, rst : SPI clock (all logic on posedge), sync active-high reset
//   dev_addr  : static device address strap
//   bus       : spi_regbank_slave_if.slave (cs/mosi/miso/miso_oe,
//               write-notify outputs, regs_flat, dbg_state)
// Build option: define SPI_REGBANK_READBACK_EN to drive the old register
// contents on miso while a write frame is being received.
module spi_regbank_slave
   import spi_regbank_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int DEV_W  = 3
) (
   input  logic                sclk,
   input  logic                rst,
   input  logic [DEV_W-1:0]    dev_addr,
   spi_regbank_slave_if.slave  bus
);

   localparam int NUM_REGS = 2**ADDR_W;
   localparam int HDR_LEN  = hdr_len(DEV_W, ADDR_W);
   localparam int ADDR_OFS = hdr_addr_ofs(DEV_W);
   localparam int RSV_OFS  = hdr_rsv_ofs(DEV_W);
   localparam int CNT_MAX  = (HDR_LEN > DATA_W) ? HDR_LEN : DATA_W;
   localparam int CNT_W    = $clog2(CNT_MAX);

`ifdef SPI_REGBANK_READBACK_EN
   localparam logic READBACK = 1'b1;
`else
   localparam logic READBACK = 1'b0;
`endif

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                is_wr_q, is_wr_d;
   logic                oe_q, oe_d;
   logic [HDR_LEN-2:0]  hdr_q;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];

   logic [HDR_LEN-1:0]  hdr_full;
   logic                hdr_wr;
   logic [DEV_W-1:0]    hdr_dev;
   logic [ADDR_W-1:0]   hdr_addr;
   logic                hdr_last;
   logic                word_end;
   logic [ADDR_W-1:0]   addr_inc;
   logic [DATA_W-1:0]   rx_word;
   logic                commit;
   logic                rx_shift;
   logic                tx_load;
   logic                tx_shift;
   logic [DATA_W-1:0]   tx_load_val;
   logic [DATA_W-1:0]   rx_q;
   logic [DATA_W-1:0]   tx_q;

   logic                hdr_rsv_unused;
   logic                rx_msb_unused;
   logic [DATA_W-2:0]   tx_low_unused;

   // The header arrives LSB first: shifting right leaves bit 0 (WR) at the
   // bottom once all bits are in; the bit on mosi completes it.
   assign hdr_full       = {bus.mosi, hdr_q};
   assign hdr_wr         = (hdr_full[HDR_WR_OFS] == OP_WR);
   assign hdr_dev        = hdr_full[HDR_DEV_OFS +: DEV_W];
   assign hdr_addr       = hdr_full[ADDR_OFS +: ADDR_W];
   assign hdr_rsv_unused = hdr_full[RSV_OFS];

   assign hdr_last = (cnt_q == CNT_W'(HDR_LEN - 1));
   assign word_end = (cnt_q == CNT_W'(DATA_W - 1));
   assign addr_inc = addr_q + 1'b1;
   assign rx_word  = {rx_q[DATA_W-2:0], bus.mosi};

   assign rx_msb_unused = rx_q[DATA_W-1];
   assign tx_low_unused = tx_q[DATA_W-2:0];

   always_ff @(posedge sclk) begin
      if (rst) begin
         state_q <= HDR;
         cnt_q   <= '0;
         addr_q  <= '0;
         is_wr_q <= 1'b0;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         is_wr_q <= is_wr_d;
         oe_q    <= oe_d;
      end
   end

   // Next state and datapath controls. cs low overrides everything and
   // drops any partially received word.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      is_wr_d     = is_wr_q;
      oe_d        = oe_q;
      commit      = 1'b0;
      rx_shift    = 1'b0;
      tx_load     = 1'b0;
      tx_shift    = 1'b0;
      tx_load_val = '0;
      if (!bus.cs) begin
         state_d = HDR;
         cnt_d   = '0;
         oe_d    = 1'b0;
         tx_load = 1'b1;
      end else begin
         case (state_q)
            HDR: begin
               if (hdr_last) begin
                  cnt_d = '0;
                  if (hdr_dev == dev_addr) begin
                     state_d = DATA;
                     addr_d  = hdr_addr;
                     is_wr_d = hdr_wr;
                     // MSB of the first word goes out on this same edge.
                     if (!hdr_wr || READBACK) begin
                        oe_d        = 1'b1;
                        tx_load     = 1'b1;
                        tx_load_val = regs_q[hdr_addr];
                     end
                  end else begin
                     state_d = SKIP;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DATA: begin
               rx_shift = 1'b1;
               if (word_end) begin
                  cnt_d  = '0;
                  addr_d = addr_inc;
                  commit = is_wr_q;
                  // Gapless burst: next register's MSB replaces the
                  // finished word on the edge that completes it.
                  if (oe_q) begin
                     tx_load     = 1'b1;
                     tx_load_val = regs_q[addr_inc];
                  end
               end else begin
                  cnt_d    = cnt_q + 1'b1;
                  tx_shift = oe_q;
               end
            end
            SKIP: begin
               state_d = SKIP;
            end
            default: begin
               state_d = HDR;
            end
         endcase
      end
   end

   always_ff @(posedge sclk) begin
      if (rst) begin
         hdr_q <= '0;
      end else if (!bus.cs) begin
         hdr_q <= '0;
      end else if (state_q == HDR) begin
         hdr_q <= {bus.mosi, hdr_q[HDR_LEN-2:1]};
      end
   end

   spi_shift_reg #(.W(DATA_W)) u_rx (
      .sclk     (sclk),
      .rst      (rst),
      .load     (!bus.cs),
      .load_val ('0),
      .shift_en (rx_shift),
      .sin      (bus.mosi),
      .q        (rx_q)
   );

   // tx is cleared whenever cs is low and only loaded while miso_oe is
   // driven, so its MSB is already 0 whenever miso must read as 0.
   spi_shift_reg #(.W(DATA_W)) u_tx (
      .sclk     (sclk),
      .rst      (rst),
      .load     (tx_load),
      .load_val (tx_load_val),
      .shift_en (tx_shift),
      .sin      (1'b0),
      .q        (tx_q)
   );

   always_ff @(posedge sclk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         bus.wr_strobe <= 1'b0;
         bus.wr_addr   <= '0;
         bus.wr_data   <= '0;
      end else begin
         bus.wr_strobe <= commit;
         if (commit) begin
            regs_q[addr_q] <= rx_word;
            bus.wr_addr    <= addr_q;
            bus.wr_data    <= rx_word;
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign bus.regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
   end

   assign bus.miso      = tx_q[DATA_W-1];
   assign bus.miso_oe   = oe_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_spi_regbank_slave.sv
// tb_spi_regbank_slave
// Directed frames against spi_regbank_slave (DATA_W=8, ADDR_W=3, DEV_W=3,
// dev_addr=5). Each frame task pushes the expected miso bits and write
// notifications into queues; a negedge monitor pops and compares whenever
// the DUT drives miso_oe or pulses wr_strobe. A register model is compared
// against regs_flat after every frame.
module tb_spi_regbank_slave;
   import spi_regbank_pkg::*;

   localparam logic [2:0] DEV = 3'd5;
`ifdef SPI_REGBANK_READBACK_EN
   localparam logic RB = 1'b1;
`else
   localparam logic RB = 1'b0;
`endif

   logic       sclk;
   logic       rst;
   logic [2:0] dev_addr;

   spi_regbank_slave_if #(.DATA_W(8), .ADDR_W(3)) bus ();

   spi_regbank_slave #(.DATA_W(8), .ADDR_W(3), .DEV_W(3)) dut (
      .sclk     (sclk),
      .rst      (rst),
      .dev_addr (dev_addr),
      .bus      (bus)
   );

   // clock / reset
   initial sclk = 1'b0;
   always #5 sclk = ~sclk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "timeout");
   end

   // scoreboard
   int         checks = 0;
   int         errors = 0;
   logic       exp_miso_q[$];
   logic [10:0] exp_wr_q[$];
   logic [7:0] model [8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] model_flat();
      logic [63:0] f;
      for (int i = 0; i < 8; i++) f[i*8 +: 8] = model[i];
      return f;
   endfunction

   always @(negedge sclk) begin
      if (!rst) begin
         if (bus.miso_oe) begin
            if (exp_miso_q.size() == 0) begin
               check("miso_oe_unexpected", 64'(bus.miso_oe), 64'(0));
            end else begin
               check("miso_bit", 64'(bus.miso), 64'(exp_miso_q.pop_front()));
            end
         end else begin
            check("miso_idle", 64'(bus.miso), 64'(0));
         end
         if (bus.wr_strobe) begin
            if (exp_wr_q.size() == 0) begin
               check("wr_strobe_unexpected", 64'(bus.wr_strobe), 64'(0));
            end else begin
               check("wr_notify", 64'({bus.wr_addr, bus.wr_data}), 64'(exp_wr_q.pop_front()));
            end
         end
      end
   end

   // drivers
   task automatic send_bit(input logic b);
      bus.cs   = 1'b1;
      bus.mosi = b;
      @(negedge sclk);
   endtask

   task automatic end_frame();
      bus.cs   = 1'b0;
      bus.mosi = 1'b0;
      @(negedge sclk);
      @(negedge sclk);
   endtask

   task automatic post_frame_checks(input string name);
      check({name, "_regs"}, bus.regs_flat, model_flat());
      check({name, "_miso_left"}, 64'(exp_miso_q.size()), 64'(0));
      check({name, "_wr_left"}, 64'(exp_wr_q.size()), 64'(0));
   endtask

   // Data stream is wdata[15], wdata[14], ... ; nbits <= 16.
   task automatic do_frame(input string name, input logic wr, input logic [2:0] dev,
                           input logic [2:0] addr, input logic rsv,
                           input int nbits, input logic [15:0] wdata);
      logic [2:0] a;
      logic [7:0] d;
      if (dev == DEV && (!wr || RB)) begin
         for (int j = 0; j <= nbits; j++) begin
            a = addr + 3'(j / 8);
            d = model[a];
            exp_miso_q.push_back(d[7 - (j % 8)]);
         end
      end
      if (dev == DEV && wr) begin
         for (int w = 0; w < nbits / 8; w++) begin
            a = addr + 3'(w);
            d = wdata[15 - 8*w -: 8];
            exp_wr_q.push_back({a, d});
            model[a] = d;
         end
      end
      send_bit(wr);
      for (int i = 0; i < 3; i++) send_bit(dev[i]);
      send_bit(rsv);
      for (int i = 0; i < 3; i++) send_bit(addr[i]);
      for (int j = 0; j < nbits; j++) send_bit(wdata[15 - j]);
      end_frame();
      post_frame_checks(name);
   endtask

   task automatic short_frame(input string name, input int k);
      for (int i = 0; i < k; i++) send_bit(1'($urandom_range(0, 1)));
      end_frame();
      post_frame_checks(name);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) model[i] = 8'h00;
      dev_addr = DEV;
      rst      = 1'b1;
      bus.cs   = 1'b0;
      bus.mosi = 1'b0;
      repeat (3) @(negedge sclk);
      check("rst_regs", bus.regs_flat, 64'(0));
      check("rst_miso", 64'(bus.miso), 64'(0));
      check("rst_miso_oe", 64'(bus.miso_oe), 64'(0));
      check("rst_wr_strobe", 64'(bus.wr_strobe), 64'(0));
      check("rst_wr_addr", 64'(bus.wr_addr), 64'(0));
      check("rst_wr_data", 64'(bus.wr_data), 64'(0));
      check("rst_state", 64'(bus.dbg_state), 64'(HDR));
      rst = 1'b0;
      @(negedge sclk);

      do_frame("rd_a2_zero",   1'b0, 3'd5, 3'd2, 1'b0, 8,  16'($urandom_range(0, 65535)));
      do_frame("wr_a3_a5",     1'b1, 3'd5, 3'd3, 1'b0, 8,  16'hA500);
      do_frame("rd_a3",        1'b0, 3'd5, 3'd3, 1'b0, 8,  16'h0000);
      do_frame("wr_burst_a7",  1'b1, 3'd5, 3'd7, 1'b0, 16, 16'h1122);
      do_frame("rd_burst_a7",  1'b0, 3'd5, 3'd7, 1'b0, 16, 16'hFFFF);
      do_frame("wr_other_dev", 1'b1, 3'd4, 3'd3, 1'b0, 8,  16'hFF00);
      do_frame("rd_other_dev", 1'b0, 3'd4, 3'd3, 1'b0, 16, 16'h0000);
      do_frame("wr_partial",   1'b1, 3'd5, 3'd3, 1'b0, 5,  16'hFFFF);
      do_frame("rd_a3_rsv1",   1'b0, 3'd5, 3'd3, 1'b1, 8,  16'h5A5A);
      do_frame("wr_a1_3c",     1'b1, 3'd5, 3'd1, 1'b0, 8,  16'h3C00);
      do_frame("wr_a1_ff",     1'b1, 3'd5, 3'd1, 1'b0, 8,  16'hFF00);
      do_frame("rd_a1",        1'b0, 3'd5, 3'd1, 1'b0, 8,  16'h0000);
      short_frame("short_hdr", 4);
      do_frame("wr_a6_burst",  1'b1, 3'd5, 3'd6, 1'b1, 16, 16'h6C93);
      do_frame("rd_a0",        1'b0, 3'd5, 3'd0, 1'b0, 16, 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
